amiga_cp_master: RTL and testbench

Parametrised clockport bus-cycle generator and the successor to amiga_cp. It turns a single-cycle req/ack command interface into a complete clockport access: address, CS_n, IORD_n/IOWR_n, data drive and read capture. Setup, hold and recovery phases are fixed by parameters, and the strobe wait-state count is set per access. It sits between the Amiga-side bus model or bridge logic and the clockport pins; tristating of the data bus is done at top level.

---
 rtl/amiga_cp_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_amiga_cp_master.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amiga_cp_master.sv
// Clockport bus-cycle master: turns a req/ack command into a full clockport access
// (address, CS_n, IORD_n/IOWR_n, write data drive, read capture) with parameterised
// setup/hold/recovery and a per-access strobe wait-state count.
// Optional feature macro: CP_INT6_LATCH_EN (sticky, clearable INT6 latch; otherwise
// irq is a synchronised level copy of the inverted INT6 line).
module amiga_cp_master #(
   parameter int unsigned ADDR_W      = 2,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned WAIT_W      = 2,
   parameter int unsigned SETUP_CYC   = 1,
   parameter int unsigned HOLD_CYC    = 1,
   parameter int unsigned RECOVER_CYC = 1,
   parameter int unsigned RESET_CYC   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              rnw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [WAIT_W-1:0] wait_states,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] cp_a,
   output logic [DATA_W-1:0] cp_d_out,
   output logic              cp_d_oe,
   input  logic [DATA_W-1:0] cp_d_in,
   output logic              cp_cs_n,
   output logic              cp_iord_n,
   output logic              cp_iowr_n,
   output logic              cp_reset_n,
   input  logic              cp_int6_n,
   input  logic              irq_clr,
   output logic              irq
);

   // One shared phase counter; sized so the longest phase (reset hold or the maximum
   // strobe of 2^WAIT_W cycles) never wraps.
   localparam int unsigned StbMax = 32'd1 << WAIT_W;
   localparam int unsigned MaxAB  = (RESET_CYC > StbMax) ? RESET_CYC : StbMax;
   localparam int unsigned MaxCD  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int unsigned MaxE   = (MaxCD > RECOVER_CYC) ? MaxCD : RECOVER_CYC;
   localparam int unsigned CntMax = (MaxAB > MaxE) ? MaxAB : MaxE;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   typedef enum logic [2:0] {
      StRstHold,
      StIdle,
      StSetup,
      StStrobe,
      StHold,
      StRecover
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              rnw_q, rnw_d;
   logic [WAIT_W-1:0] ws_q, ws_d;
   logic              cs_n_q, cs_n_d;
   logic              iord_n_q, iord_n_d;
   logic              iowr_n_q, iowr_n_d;
   logic              d_oe_q, d_oe_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] d_out_q, d_out_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ack_q, ack_d;
   logic              busy_q, busy_d;
   logic              reset_n_q, reset_n_d;

   // Next-state and next-output logic; outputs are registered together with the state so
   // state_q always describes what the pins currently show.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rnw_d     = rnw_q;
      ws_d      = ws_q;
      cs_n_d    = cs_n_q;
      iord_n_d  = iord_n_q;
      iowr_n_d  = iowr_n_q;
      d_oe_d    = d_oe_q;
      a_d       = a_q;
      d_out_d   = d_out_q;
      rdata_d   = rdata_q;
      ack_d     = 1'b0;
      busy_d    = busy_q;
      reset_n_d = reset_n_q;

      case (state_q)
         StRstHold: begin
            if (cnt_q == CntW'(RESET_CYC - 1)) begin
               reset_n_d = 1'b1;
               busy_d    = 1'b0;
               cnt_d     = '0;
               state_d   = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StIdle: begin
            if (req) begin
               rnw_d   = rnw;
               ws_d    = wait_states;
               a_d     = addr;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               d_oe_d  = ~rnw;
               // Reads leave the last written value on cp_d_out.
               d_out_d = rnw ? d_out_q : wdata;
               cnt_d   = '0;
               state_d = StSetup;
            end
         end
         StSetup: begin
            if (cnt_q == CntW'(SETUP_CYC - 1)) begin
               iord_n_d = ~rnw_q;
               iowr_n_d = rnw_q;
               cnt_d    = '0;
               state_d  = StStrobe;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StStrobe: begin
            if (cnt_q == CntW'(ws_q)) begin
               iord_n_d = 1'b1;
               iowr_n_d = 1'b1;
               // Capture on the edge that releases the read strobe.
               if (rnw_q) begin
                  rdata_d = cp_d_in;
               end
               cnt_d   = '0;
               state_d = StHold;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StHold: begin
            if (cnt_q == CntW'(HOLD_CYC - 1)) begin
               cs_n_d = 1'b1;
               d_oe_d = 1'b0;
               ack_d  = 1'b1;
               cnt_d  = '0;
               // The ack cycle counts as the first recovery cycle.
               if (RECOVER_CYC == 0) begin
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  state_d = StRecover;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRecover: begin
            if (cnt_q == CntW'(RECOVER_CYC - 1)) begin
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = StRstHold;
            cnt_d   = '0;
         end
      endcase
   end

   // State and registered outputs; rst forces the bus idle and restarts the reset hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StRstHold;
         cnt_q     <= '0;
         rnw_q     <= 1'b0;
         ws_q      <= '0;
         cs_n_q    <= 1'b1;
         iord_n_q  <= 1'b1;
         iowr_n_q  <= 1'b1;
         d_oe_q    <= 1'b0;
         a_q       <= '0;
         d_out_q   <= '0;
         rdata_q   <= '0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b1;
         reset_n_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rnw_q     <= rnw_d;
         ws_q      <= ws_d;
         cs_n_q    <= cs_n_d;
         iord_n_q  <= iord_n_d;
         iowr_n_q  <= iowr_n_d;
         d_oe_q    <= d_oe_d;
         a_q       <= a_d;
         d_out_q   <= d_out_d;
         rdata_q   <= rdata_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         reset_n_q <= reset_n_d;
      end
   end

   assign cp_cs_n    = cs_n_q;
   assign cp_iord_n  = iord_n_q;
   assign cp_iowr_n  = iowr_n_q;
   assign cp_d_oe    = d_oe_q;
   assign cp_a       = a_q;
   assign cp_d_out   = d_out_q;
   assign rdata      = rdata_q;
   assign ack        = ack_q;
   assign busy       = busy_q;
   assign cp_reset_n = reset_n_q;

   // INT6 path: two-flop synchroniser, then either a sticky latch or a level copy.
   logic int_s1_q, int_s2_q;
   logic irq_q, irq_d;

`ifdef CP_INT6_LATCH_EN
   logic int_s3_q;

   // Sticky irq: a synchronised falling edge sets it and beats a same-cycle clear.
   always_comb begin
      irq_d = irq_q;
      if (int_s3_q && !int_s2_q) begin
         irq_d = 1'b1;
      end else if (irq_clr) begin
         irq_d = 1'b0;
      end
   end

   // Synchroniser plus edge-detect history flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         int_s1_q <= 1'b1;
         int_s2_q <= 1'b1;
         int_s3_q <= 1'b1;
         irq_q    <= 1'b0;
      end else begin
         int_s1_q <= cp_int6_n;
         int_s2_q <= int_s1_q;
         int_s3_q <= int_s2_q;
         irq_q    <= irq_d;
      end
   end
`else
   logic unused_irq_clr;
   assign unused_irq_clr = irq_clr;

   // Level pass-through of the synchronised, inverted INT6 line.
   always_comb begin
      irq_d = ~int_s2_q;
   end

   // Synchroniser and registered irq.
   always_ff @(posedge clk) begin
      if (rst) begin
         int_s1_q <= 1'b1;
         int_s2_q <= 1'b1;
         irq_q    <= 1'b0;
      end else begin
         int_s1_q <= cp_int6_n;
         int_s2_q <= int_s1_q;
         irq_q    <= irq_d;
      end
   end
`endif

   assign irq = irq_q;

endmodule

// File: tb/tb_amiga_cp_master.sv
// Bench for amiga_cp_master: table of single accesses, a scoreboard of expected read
// data popped on every ack, plus sequences for reset, back-to-back, mid-access reset
// and INT6 handling.
module tb_amiga_cp_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic       rnw;
   logic [1:0] addr;
   logic [7:0] wdata;
   logic [1:0] wait_states;
   logic       ack;
   logic [7:0] rdata;
   logic       busy;
   logic [1:0] cp_a;
   logic [7:0] cp_d_out;
   logic       cp_d_oe;
   logic [7:0] cp_d_in;
   logic       cp_cs_n;
   logic       cp_iord_n;
   logic       cp_iowr_n;
   logic       cp_reset_n;
   logic       cp_int6_n;
   logic       irq_clr;
   logic       irq;

   amiga_cp_master #(
      .ADDR_W      (2),
      .DATA_W      (8),
      .WAIT_W      (2),
      .SETUP_CYC   (1),
      .HOLD_CYC    (1),
      .RECOVER_CYC (1),
      .RESET_CYC   (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .rnw         (rnw),
      .addr        (addr),
      .wdata       (wdata),
      .wait_states (wait_states),
      .ack         (ack),
      .rdata       (rdata),
      .busy        (busy),
      .cp_a        (cp_a),
      .cp_d_out    (cp_d_out),
      .cp_d_oe     (cp_d_oe),
      .cp_d_in     (cp_d_in),
      .cp_cs_n     (cp_cs_n),
      .cp_iord_n   (cp_iord_n),
      .cp_iowr_n   (cp_iowr_n),
      .cp_reset_n  (cp_reset_n),
      .cp_int6_n   (cp_int6_n),
      .irq_clr     (irq_clr),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rnw;
      logic [1:0] addr;
      logic [7:0] wdata;
      logic [1:0] ws;
      logic [7:0] din;
      int         exp_cs;
      int         exp_stb;
      int         exp_lat;
   } vec_t;

   typedef struct packed {
      logic       rnw;
      logic [7:0] rdata;
   } exp_t;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         ack_cnt = 0;
   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] model_rdata = 8'h00;
   vec_t       vecs[6];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Scoreboard: every ack must match a pending access and carry the modelled rdata.
   always @(negedge clk) begin
      if (ack === 1'b1) begin
         ack_cnt++;
         check("ack_has_pending_access", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("ack_rdata", int'(rdata), int'(mon_e.rdata));
         end
      end
   end

   task automatic push_expect(input logic r, input logic [7:0] din);
      exp_t e;
      if (r) model_rdata = din;
      e.rnw   = r;
      e.rdata = model_rdata;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int w = 0;
      while (busy !== 1'b0 && w < 40) begin
         @(negedge clk);
         w++;
      end
      check(name, int'(busy), 0);
   endtask

   // One access; called at a negedge with busy low.
   task automatic do_access(input vec_t v);
      int cs_low = 0, rd_low = 0, wr_low = 0, bad = 0, lat = -1;
      int cs_at_ack = 0, oe_at_ack = 1;
      req         = 1'b1;
      rnw         = v.rnw;
      addr        = v.addr;
      wdata       = v.wdata;
      wait_states = v.ws;
      cp_d_in     = v.din;
      push_expect(v.rnw, v.din);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("accept_busy", int'(busy), 1);
            req = 1'b0;
         end
         if (cp_cs_n == 1'b0) begin
            cs_low++;
            if (cp_a != v.addr) bad++;
            if (cp_d_oe != !v.rnw) bad++;
            if (!v.rnw && cp_d_out != v.wdata) bad++;
         end
         if (cp_iord_n == 1'b0) rd_low++;
         if (cp_iowr_n == 1'b0) wr_low++;
         if ((!cp_iord_n || !cp_iowr_n) && cp_cs_n) bad++;
         if (ack) begin
            lat       = k;
            cs_at_ack = int'(cp_cs_n);
            oe_at_ack = int'(cp_d_oe);
            break;
         end
      end
      check("ack_latency", lat, v.exp_lat);
      check("cs_low_cycles", cs_low, v.exp_cs);
      check("strobe_cycles", v.rnw ? rd_low : wr_low, v.exp_stb);
      check("other_strobe_idle", v.rnw ? wr_low : rd_low, 0);
      check("bus_during_cs", bad, 0);
      check("cs_high_at_ack", cs_at_ack, 1);
      check("oe_off_at_ack", oe_at_ack, 0);
      wait_idle("return_idle");
      check("addr_held_idle", int'(cp_a), int'(v.addr));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, cs_seen, busy_bad, hi, first, seen, gap_bad, acks0;
      int acc_t[$];
      logic prev_cs;

      // rnw addr wdata ws din | cs_low strobe latency
      vecs[0] = '{1'b0, 2'd2, 8'hA5, 2'd0, 8'h00, 3, 1, 4};
      vecs[1] = '{1'b1, 2'd1, 8'h00, 2'd3, 8'h3C, 6, 4, 7};
      vecs[2] = '{1'b0, 2'd3, 8'h5A, 2'd3, 8'hFF, 6, 4, 7};
      vecs[3] = '{1'b1, 2'd0, 8'h11, 2'd0, 8'hC3, 3, 1, 4};
      vecs[4] = '{1'b0, 2'd1, 8'h0F, 2'd2, 8'h99, 5, 3, 6};
      vecs[5] = '{1'b1, 2'd2, 8'h00, 2'd1, 8'h7E, 4, 2, 5};

      rst = 1'b1; req = 1'b0; rnw = 1'b0; addr = '0; wdata = '0; wait_states = '0;
      cp_d_in = '0; cp_int6_n = 1'b1; irq_clr = 1'b0;

      // Reset: three cycles of rst, then 16 cycles of cp_reset_n low with req ignored.
      repeat (3) @(negedge clk);
      check("rst_cs_n", int'(cp_cs_n), 1);
      check("rst_iord_n", int'(cp_iord_n), 1);
      check("rst_iowr_n", int'(cp_iowr_n), 1);
      check("rst_d_oe", int'(cp_d_oe), 0);
      check("rst_cp_a", int'(cp_a), 0);
      check("rst_d_out", int'(cp_d_out), 0);
      check("rst_rdata", int'(rdata), 0);
      check("rst_ack", int'(ack), 0);
      check("rst_busy", int'(busy), 1);
      check("rst_cp_reset_n", int'(cp_reset_n), 0);
      check("rst_irq", int'(irq), 0);
      rst = 1'b0;
      req = 1'b1;
      cnt = 0; cs_seen = 0; busy_bad = 0;
      while (cp_reset_n == 1'b0 && cnt < 100) begin
         cnt++;
         if (!cp_cs_n) cs_seen++;
         if (!busy) busy_bad++;
         @(negedge clk);
      end
      req = 1'b0;
      check("reset_hold_cycles", cnt, 16);
      check("reset_hold_no_cs", cs_seen, 0);
      check("reset_hold_busy", busy_bad, 0);
      check("reset_done_busy", int'(busy), 0);
      @(negedge clk);
      check("req_during_reset_dropped", int'(cp_cs_n), 1);

      // Single accesses from the table.
      for (int i = 0; i < 6; i++) begin
         do_access(vecs[i]);
      end

      // Back-to-back: req held, rnw alternating, wait_states=1 -> accept every 6 cycles.
      acks0 = ack_cnt;
      req = 1'b1; rnw = 1'b0; addr = 2'd2; wdata = 8'h6B; wait_states = 2'd1;
      cp_d_in = 8'h5A;
      prev_cs = 1'b1; gap_bad = 0;
      for (int k = 1; k <= 60 && acc_t.size() < 4; k++) begin
         @(negedge clk);
         if (ack && !cp_cs_n) gap_bad++;
         if (prev_cs && !cp_cs_n) begin
            acc_t.push_back(k);
            push_expect(rnw, cp_d_in);
            rnw = ~rnw;
         end
         prev_cs = cp_cs_n;
      end
      req = 1'b0;
      wait_idle("b2b_idle");
      check("b2b_accepts", acc_t.size(), 4);
      for (int i = 1; i < acc_t.size(); i++) begin
         check("b2b_period", acc_t[i] - acc_t[i-1], 6);
      end
      check("b2b_ack_count", ack_cnt - acks0, 4);
      check("b2b_ack_overlap", gap_bad, 0);

      // rst during a write strobe: bus idles at once and the access never acks.
      @(negedge clk);
      req = 1'b1; rnw = 1'b0; addr = 2'd3; wdata = 8'h81; wait_states = 2'd3;
      push_expect(1'b0, 8'h00);
      seen = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) req = 1'b0;
         if (!cp_iowr_n) begin
            seen = 1;
            break;
         end
      end
      check("midrst_strobe_seen", seen, 1);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      check("midrst_cs_n", int'(cp_cs_n), 1);
      check("midrst_iowr_n", int'(cp_iowr_n), 1);
      check("midrst_d_oe", int'(cp_d_oe), 0);
      check("midrst_ack", int'(ack), 0);
      check("midrst_cp_reset_n", int'(cp_reset_n), 0);
      rst = 1'b0;
      model_rdata = 8'h00;
      cnt = 0;
      while (cp_reset_n == 1'b0 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("midrst_reset_hold", cnt, 16);
      check("midrst_rdata_cleared", int'(rdata), 0);
      do_access(vecs[3]);

      // INT6: one-cycle low pulse reaches irq three cycles later.
      @(negedge clk);
      cp_int6_n = 1'b0;
      first = -1; hi = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) cp_int6_n = 1'b1;
         if (irq && first < 0) first = k;
         if (irq) hi++;
      end
      check("irq_delay", first, 3);
`ifdef CP_INT6_LATCH_EN
      check("irq_sticky", hi, 6);
      // New falling edge with clear in the same cycle: set wins.
      cp_int6_n = 1'b0;
      @(negedge clk);
      cp_int6_n = 1'b1;
      @(negedge clk);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      check("irq_set_beats_clr", int'(irq), 1);
      @(negedge clk);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      check("irq_clr_alone", int'(irq), 0);
`else
      check("irq_level_width", hi, 1);
      // irq follows the held level; irq_clr has no effect.
      cp_int6_n = 1'b0;
      irq_clr   = 1'b1;
      repeat (4) @(negedge clk);
      check("irq_level_held", int'(irq), 1);
      cp_int6_n = 1'b1;
      repeat (4) @(negedge clk);
      irq_clr = 1'b0;
      check("irq_level_released", int'(irq), 0);
`endif

      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
